// File: rtl/piso_pkg.sv
// Shared state encoding and frame-length helper for the piso_tx transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  function automatic int frame_len(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Frame bit counter: sync clear has priority over enable; tc marks the final frame bit.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int CW   = 4,
  parameter int FLEN = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(FLEN - 1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/piso_tx.sv
// piso_tx: LSB-first parallel-to-serial transmitter with a valid/ready load port.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int CNT_W = $clog2(WIDTH);
  localparam int FLEN  = frame_len(WIDTH, PAR_EN);
  localparam logic [CNT_W:0] LAST_DATA = (CNT_W + 1)'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             ser_out_nxt;
  logic [CNT_W:0]   cnt;
  logic             tc;
  logic             accept;
  logic             data_done;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  piso_bit_cnt #(
    .CW   (CNT_W + 1),
    .FLEN (FLEN)
  ) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   ((state == ST_IDLE) || tc),
    .en    (busy),
    .cnt   (cnt),
    .tc    (tc)
  );

  assign busy       = (state != ST_IDLE);
  assign ser_last   = tc;
  assign load_ready = (state == ST_IDLE) || ser_last;
  assign accept     = load_valid && load_ready;
  assign data_done  = (cnt == LAST_DATA);

  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    ser_out_nxt = 1'b0;
    unique case (state)
      ST_IDLE: state_nxt = ST_IDLE;
      ST_SHIFT: begin
        if (data_done) begin
`ifdef PISO_PARITY_EN
          state_nxt   = ST_PARITY;
          ser_out_nxt = par;
`else
          state_nxt   = ST_IDLE;
`endif
          sreg_nxt = '0;
        end else begin
          ser_out_nxt = sreg[0];
          sreg_nxt    = sreg >> 1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A new word can only arrive when idle or on the last frame bit, so it wins here.
    if (accept) begin
      state_nxt   = ST_SHIFT;
      sreg_nxt    = load_data >> 1;
      ser_out_nxt = load_data[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sreg      <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      ser_out   <= ser_out_nxt;
      ser_valid <= (state_nxt != ST_IDLE);
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^load_data;
    end
  end
`endif

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx: directed vector table plus randomized run against a bit-queue model.
module tb_piso_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // exp packs {load_ready, ser_out, ser_valid, ser_last, busy} seen after the edge.
  typedef struct {
    logic         rst;
    logic         lv;
    logic [W-1:0] ld;
    logic [4:0]   exp;
  } vec_t;

  vec_t vecs[$];
  bit   model_q[$];

  // Expected bit streams written in transmission order (leftmost bit goes first).
  localparam logic [7:0]  SEQ_A5 = 8'b1010_0101;
  localparam logic [15:0] SEQ_BB = 16'b1000_0000_1111_1111;
  localparam logic [7:0]  SEQ_3C = 8'b0011_1100;
  localparam logic [7:0]  SEQ_FF = 8'b1111_1111;
  localparam logic [7:0]  SEQ_80 = 8'b0000_0001;
  localparam logic [8:0]  SEQ_07 = 9'b1110_0000_1;
  localparam logic [8:0]  SEQ_03 = 9'b1100_0000_0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  function automatic void add(input logic rst, input logic lv, input logic [W-1:0] ld,
                              input logic eo, input logic ev, input logic el,
                              input logic er, input logic eb);
    vec_t v;
    v.rst = rst;
    v.lv  = lv;
    v.ld  = ld;
    v.exp = {er, eo, ev, el, eb};
    vecs.push_back(v);
  endfunction

  function automatic void add_quiet(input logic rst, input logic lv, input logic [W-1:0] ld);
    add(rst, lv, ld, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b (ready,out,valid,last,busy)", name, act, exp);
    end
  endtask

  initial begin
    logic [4:0] e;
    bit         exp_ready;
    bit         acc;

    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;

`ifdef PISO_PARITY_EN
    add_quiet(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 9; k++)
      add(1'b0, k == 0, 8'h07, SEQ_07[8-k], 1'b1, k == 8, k == 8, 1'b1);
    add_quiet(1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 9; k++)
      add(1'b0, k == 0, 8'h03, SEQ_03[8-k], 1'b1, k == 8, k == 8, 1'b1);
    add_quiet(1'b0, 1'b0, 8'h00);
`else
    // Single word, then idle.
    add_quiet(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++)
      add(1'b0, k == 0, (k == 0) ? 8'hA5 : 8'h00, SEQ_A5[7-k], 1'b1, k == 7, k == 7, 1'b1);
    add_quiet(1'b0, 1'b0, 8'h00);
    // Back-to-back: second word is held valid and taken on the first word's last bit.
    for (int k = 0; k < 16; k++)
      add(1'b0, k <= 8, (k == 0) ? 8'h01 : 8'hFF, SEQ_BB[15-k], 1'b1,
          (k == 7) || (k == 15), (k == 7) || (k == 15), 1'b1);
    add_quiet(1'b0, 1'b0, 8'h00);
    // Valid pulse mid-frame must be ignored.
    for (int k = 0; k < 8; k++)
      add(1'b0, (k == 0) || (k == 4), (k == 0) ? 8'h3C : 8'h00, SEQ_3C[7-k], 1'b1,
          k == 7, k == 7, 1'b1);
    add_quiet(1'b0, 1'b0, 8'h00);
    // Reset mid-frame, then a clean frame.
    for (int k = 0; k < 5; k++)
      add(1'b0, k == 0, 8'hFF, SEQ_FF[7-k], 1'b1, 1'b0, 1'b0, 1'b1);
    add_quiet(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 8; k++)
      add(1'b0, k == 0, 8'h80, SEQ_80[7-k], 1'b1, k == 7, k == 7, 1'b1);
    add_quiet(1'b0, 1'b0, 8'h00);
`endif
    // Reset held with a valid word present: nothing may be accepted.
    for (int k = 0; k < 3; k++)
      add_quiet(1'b1, 1'b1, 8'h55);
    add_quiet(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      reset      = vecs[i].rst;
      load_valid = vecs[i].lv;
      load_data  = vecs[i].ld;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {load_ready, ser_out, ser_valid, ser_last, busy}, vecs[i].exp);
    end

    // Randomized traffic: the model holds every bit still to appear on the line.
    model_q.delete();
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = W'($urandom);
      exp_ready  = (model_q.size() <= 1);
      acc        = load_valid && exp_ready && !reset;
      @(posedge clk);
      #1;
      if (reset) begin
        model_q.delete();
      end else begin
        if (model_q.size() > 0) void'(model_q.pop_front());
        if (acc) begin
          for (int b = 0; b < W; b++) model_q.push_back(load_data[b]);
`ifdef PISO_PARITY_EN
          model_q.push_back(^load_data);
`endif
        end
      end
      e = {model_q.size() <= 1,
           (model_q.size() > 0) ? model_q[0] : 1'b0,
           model_q.size() > 0,
           model_q.size() == 1,
           model_q.size() > 0};
      check($sformatf("rand%0d", c), {load_ready, ser_out, ser_valid, ser_last, busy}, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
